// File: rtl/adc_spi_ctrl.sv
`timescale 1ns/1ps
// adc_spi_ctrl: SPI master for the ADC128S022 8-channel 12-bit ADC.
// A CPU write starts one conversion on the requested channel. Because the ADC
// converts the channel addressed in the previous frame, an extra PRIME frame is
// sent whenever the ADC's address pointer is not already known to match.
module adc_spi_ctrl #(
    parameter int CLK_DIV = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ADC_WE,
    input  logic [31:0] ADC_WD,
    output logic [31:0] ADC_RD,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_DIN,
    input  logic        ADC_DOUT
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_BITS  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_phase;
    logic [2:0]       r_reqCh;
    logic [2:0]       r_lastCh;
    logic [2:0]       r_resCh;
    logic             r_chanKnown;
    logic             r_prime;
    logic             r_busy;
    logic             r_valid;
    logic [11:0]      r_shift;
    logic [11:0]      r_result;
    logic             r_csN;
    logic             r_sclk;
    logic             r_din;

    logic             w_phaseEnd;
    logic [3:0]       w_slot;
    logic [3:0]       w_nextSlot;
    logic             w_needPrime;
    logic             w_unusedWdBits;

    // Phase phase r_phase holds 2*slot + (0 falling, 1 rising)
    assign w_phaseEnd     = (r_div == DIV_LAST);
    assign w_slot         = r_phase[4:1];
    assign w_nextSlot     = w_slot + 4'd1;
    assign w_needPrime    = !(r_chanKnown && (r_lastCh == ADC_WD[2:0]));
    assign w_unusedWdBits = ^ADC_WD[31:3];

    assign ADC_RD   = {r_busy, r_valid, 11'd0, r_resCh, 4'd0, r_result};
    assign ADC_CS_N = r_csN;
    assign ADC_SCLK = r_sclk;
    assign ADC_DIN  = r_din;

    // Address bits go out MSB first in slots 2..4; every other slot sends 0
    function automatic logic dinFor(input logic [3:0] slot, input logic [2:0] ch);
        case (slot)
            4'd2:    dinFor = ch[2];
            4'd3:    dinFor = ch[1];
            4'd4:    dinFor = ch[0];
            default: dinFor = 1'b0;
        endcase
    endfunction

    // Divider restarts at every phase boundary so each phase lasts exactly CLK_DIV cycles
    always_ff @(posedge CLK) begin
        if (RESET || r_state == ST_IDLE || r_state == ST_DONE || w_phaseEnd) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Frame sequencer: drives CS/SCLK/DIN, shifts in DOUT and publishes the result
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_reqCh     <= '0;
            r_lastCh    <= '0;
            r_resCh     <= '0;
            r_chanKnown <= 1'b0;
            r_prime     <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_shift     <= '0;
            r_result    <= '0;
            r_csN       <= 1'b1;
            r_sclk      <= 1'b1;
            r_din       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ADC_WE) begin
                        r_reqCh <= ADC_WD[2:0];
                        r_prime <= w_needPrime;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_csN   <= 1'b0;
                        r_sclk  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_phaseEnd) begin
                        r_state <= ST_BITS;
                        r_phase <= '0;
                        r_sclk  <= 1'b0;
                        r_din   <= dinFor(4'd0, r_reqCh);
                    end
                end
                ST_BITS: begin
                    if (w_phaseEnd) begin
                        r_phase <= r_phase + 5'd1;
                        if (!r_phase[0]) begin
                            r_sclk <= 1'b1;
                            if (w_slot >= 4'd4) begin
                                r_shift <= {r_shift[10:0], ADC_DOUT};
                            end
                        end else if (r_phase == 5'd31) begin
                            r_state <= ST_GAP;
                            r_csN   <= 1'b1;
                            r_din   <= 1'b0;
                        end else begin
                            r_sclk <= 1'b0;
                            r_din  <= dinFor(w_nextSlot, r_reqCh);
                        end
                    end
                end
                ST_GAP: begin
                    if (w_phaseEnd) begin
                        r_lastCh    <= r_reqCh;
                        r_chanKnown <= 1'b1;
                        if (r_prime) begin
                            r_prime <= 1'b0;
                            r_csN   <= 1'b0;
                            r_state <= ST_SETUP;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_result <= r_shift;
                    r_resCh  <= r_reqCh;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_ctrl.sv
`timescale 1ns/1ps
// tb_adc_spi_ctrl: two controllers (CLK_DIV=4 and CLK_DIV=1) each talking to a
// behavioural ADC128S022 model; expectations come from the ADC's frame rules.
module tb_adc_spi_ctrl;
    localparam int DIV0 = 4;
    localparam int DIV1 = 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [31:0] rd0, rd1;
    logic        csN0, csN1, sclk0, sclk1, din0, din1;
    logic        dout0 = 1'b0, dout1 = 1'b0;

    int errors = 0;
    int checks = 0;

    // ADC model state, per controller instance
    logic [11:0] chanVal [2][8];
    logic [1:0]  leadOnes = '0;
    logic [2:0]  addrPtr [2] = '{3'd0, 3'd0};
    int          slot [2] = '{0, 0};
    logic [11:0] curData [2];
    logic [15:0] dinSeen [2];
    int          frames [2] = '{0, 0};
    time         csStart [2] = '{0, 0};
    time         lastRise [2] = '{0, 0};
    time         lastFall [2] = '{0, 0};
    time         prevFall [2] = '{0, 0};
    int          frameLen [2][8];
    int          gapLen [2][8];
    int          sclkPer [2][8];
    logic [15:0] frameDin [2][8];

    // Expectation model: does the controller already know the ADC's address pointer
    logic        known [2];
    logic [2:0]  lastCh [2];

    adc_spi_ctrl #(.CLK_DIV(DIV0)) dut0 (
        .CLK(CLK), .RESET(RESET), .ADC_WE(we0), .ADC_WD(wd0), .ADC_RD(rd0),
        .ADC_CS_N(csN0), .ADC_SCLK(sclk0), .ADC_DIN(din0), .ADC_DOUT(dout0)
    );
    adc_spi_ctrl #(.CLK_DIV(DIV1)) dut1 (
        .CLK(CLK), .RESET(RESET), .ADC_WE(we1), .ADC_WD(wd1), .ADC_RD(rd1),
        .ADC_CS_N(csN1), .ADC_SCLK(sclk1), .ADC_DIN(din1), .ADC_DOUT(dout1)
    );

    always #5 CLK = ~CLK;

    function automatic int divOf(input int u);
        return (u == 0) ? DIV0 : DIV1;
    endfunction
    function automatic logic [31:0] rdOf(input int u);
        return (u == 0) ? rd0 : rd1;
    endfunction
    function automatic logic csOf(input int u);
        return (u == 0) ? csN0 : csN1;
    endfunction
    function automatic logic sclkOf(input int u);
        return (u == 0) ? sclk0 : sclk1;
    endfunction
    function automatic logic dinOf(input int u);
        return (u == 0) ? din0 : din1;
    endfunction
    function automatic logic [31:0] expWord(input logic [2:0] ch, input logic [11:0] val);
        return {2'b01, 11'd0, ch, 4'd0, val};
    endfunction

    task automatic driveWrite(input int u, input logic en, input logic [31:0] data);
        if (u == 0) begin we0 = en; wd0 = data; end
        else begin we1 = en; wd1 = data; end
    endtask

    // ADC: chip select falling starts a frame converting the previously addressed channel
    task automatic csFall(input int u);
        slot[u] = 0;
        curData[u] = chanVal[u][addrPtr[u]];
        dinSeen[u] = '0;
        gapLen[u][frames[u] % 8] = int'(($time - lastRise[u]) / 10);
        csStart[u] = $time;
    endtask

    task automatic csRise(input int u);
        frameLen[u][frames[u] % 8] = int'(($time - csStart[u]) / 10);
        frameDin[u][frames[u] % 8] = dinSeen[u];
        sclkPer[u][frames[u] % 8] = int'((lastFall[u] - prevFall[u]) / 10);
        frames[u]++;
        lastRise[u] = $time;
    endtask

    // ADC: puts the next data bit on DOUT at each SCLK falling edge
    task automatic sclkFall(input int u);
        logic bitVal;
        if (csOf(u) == 1'b0) begin
            if (slot[u] < 4) bitVal = leadOnes[u];
            else if (slot[u] < 16) bitVal = curData[u][15 - slot[u]];
            else bitVal = 1'b0;
            if (u == 0) dout0 = bitVal;
            else dout1 = bitVal;
            prevFall[u] = lastFall[u];
            lastFall[u] = $time;
            slot[u]++;
        end
    endtask

    // ADC: samples DIN at each SCLK rising edge; the address is complete after slot 4
    task automatic sclkRise(input int u);
        int k;
        if (csOf(u) == 1'b0 && slot[u] >= 1 && slot[u] <= 16) begin
            k = slot[u] - 1;
            dinSeen[u][15 - k] = dinOf(u);
            if (k == 4) addrPtr[u] = dinSeen[u][13:11];
        end
    endtask

    always @(negedge csN0) csFall(0);
    always @(posedge csN0) csRise(0);
    always @(negedge sclk0) sclkFall(0);
    always @(posedge sclk0) sclkRise(0);
    always @(negedge csN1) csFall(1);
    always @(posedge csN1) csRise(1);
    always @(negedge sclk1) sclkFall(1);
    always @(posedge sclk1) sclkRise(1);

    // Issues one write and waits (bounded) for VALID; lat counts clock edges after the accepting edge
    task automatic runRequest(input int u, input logic [2:0] ch, input int injectAt, input logic [2:0] injCh,
                              output int lat, output logic [31:0] rdOut, output int nFr, output int f0,
                              output logic [31:0] acceptWord, output logic statusBad);
        int budget;
        logic [31:0] cur;
        budget = 2 * 34 * divOf(u) + 20;
        f0 = frames[u];
        @(negedge CLK);
        driveWrite(u, 1'b1, {29'($urandom), ch});
        @(posedge CLK);
        @(negedge CLK);
        driveWrite(u, 1'b0, 32'd0);
        acceptWord = rdOf(u);
        statusBad = 1'b0;
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            if (k == injectAt) driveWrite(u, 1'b1, {29'($urandom), injCh});
            @(posedge CLK);
            @(negedge CLK);
            driveWrite(u, 1'b0, 32'd0);
            cur = rdOf(u);
            if (cur[30]) begin
                lat = k;
                break;
            end
            if (cur[31] !== 1'b1) statusBad = 1'b1;
        end
        rdOut = rdOf(u);
        nFr = frames[u] - f0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < 8; c++) chanVal[u][c] = 12'($urandom);
            known[u] = 1'b0;
            lastCh[u] = 3'd0;
        end
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int u = 0; u < 2; u++) begin
            r = rdOf(u);
            checks++;
            if (csOf(u) !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n[%0d]: got %b want 1", u, csOf(u)); end
            checks++;
            if (sclkOf(u) !== 1'b1) begin errors++; $display("[TB] FAIL reset_sclk[%0d]: got %b want 1", u, sclkOf(u)); end
            checks++;
            if (dinOf(u) !== 1'b0) begin errors++; $display("[TB] FAIL reset_din[%0d]: got %b want 0", u, dinOf(u)); end
            checks++;
            if (r !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd[%0d]: got %h want 00000000", u, r); end
        end
        RESET = 1'b0;
    endtask

    task automatic test_two_frame();
        int lat, nFr, f0;
        logic [31:0] rdv, acc;
        logic bad;
        chanVal[0][5] = 12'hA5C;
        runRequest(0, 3'd5, 0, 3'd0, lat, rdv, nFr, f0, acc, bad);
        known[0] = 1'b1; lastCh[0] = 3'd5;
        checks++;
        if (acc[31:30] !== 2'b10) begin errors++; $display("[TB] FAIL two_frame_accept_status: got %b want 10", acc[31:30]); end
        checks++;
        if (lat !== 2 * 34 * DIV0 + 1) begin errors++; $display("[TB] FAIL two_frame_latency: got %0d want %0d", lat, 2 * 34 * DIV0 + 1); end
        checks++;
        if (rdv !== 32'h4005_0A5C) begin errors++; $display("[TB] FAIL two_frame_rd: got %h want 40050a5c", rdv); end
        checks++;
        if (nFr !== 2) begin errors++; $display("[TB] FAIL two_frame_count: got %0d want 2", nFr); end
        for (int i = 0; i < nFr && i < 2; i++) begin
            checks++;
            if (frameLen[0][(f0 + i) % 8] !== 33 * DIV0) begin
                errors++; $display("[TB] FAIL two_frame_cs_low[%0d]: got %0d want %0d", i, frameLen[0][(f0 + i) % 8], 33 * DIV0);
            end
            checks++;
            if (frameDin[0][(f0 + i) % 8] !== 16'h2800) begin
                errors++; $display("[TB] FAIL two_frame_din[%0d]: got %h want 2800", i, frameDin[0][(f0 + i) % 8]);
            end
        end
        if (nFr >= 2) begin
            checks++;
            if (gapLen[0][(f0 + 1) % 8] !== DIV0) begin
                errors++; $display("[TB] FAIL two_frame_gap: got %0d want %0d", gapLen[0][(f0 + 1) % 8], DIV0);
            end
        end
    endtask

    task automatic test_same_channel();
        int lat, nFr, f0;
        logic [31:0] rdv, acc;
        logic bad;
        chanVal[0][5] = 12'h123;
        runRequest(0, 3'd5, 0, 3'd0, lat, rdv, nFr, f0, acc, bad);
        checks++;
        if (lat !== 34 * DIV0 + 1) begin errors++; $display("[TB] FAIL same_ch_latency: got %0d want %0d", lat, 34 * DIV0 + 1); end
        checks++;
        if (rdv !== 32'h4005_0123) begin errors++; $display("[TB] FAIL same_ch_rd: got %h want 40050123", rdv); end
        checks++;
        if (nFr !== 1) begin errors++; $display("[TB] FAIL same_ch_count: got %0d want 1", nFr); end
    endtask

    task automatic test_busy_write();
        int lat, nFr, f0;
        logic [31:0] rdv, acc, r;
        logic bad;
        chanVal[0][3] = 12'h3C7;
        chanVal[0][2] = 12'h888;
        runRequest(0, 3'd3, 40, 3'd2, lat, rdv, nFr, f0, acc, bad);
        known[0] = 1'b1; lastCh[0] = 3'd3;
        checks++;
        if (bad !== 1'b0) begin errors++; $display("[TB] FAIL busy_status_during: got %b want 0", bad); end
        checks++;
        if (lat !== 2 * 34 * DIV0 + 1) begin errors++; $display("[TB] FAIL busy_latency: got %0d want %0d", lat, 2 * 34 * DIV0 + 1); end
        checks++;
        if (rdv !== 32'h4003_03C7) begin errors++; $display("[TB] FAIL busy_rd: got %h want 400303c7", rdv); end
        checks++;
        if (nFr !== 2) begin errors++; $display("[TB] FAIL busy_count: got %0d want 2", nFr); end
        for (int i = 0; i < nFr && i < 2; i++) begin
            checks++;
            if (frameDin[0][(f0 + i) % 8] !== 16'h1800) begin
                errors++; $display("[TB] FAIL busy_din[%0d]: got %h want 1800", i, frameDin[0][(f0 + i) % 8]);
            end
        end
        // A write landing in the one-cycle completion state must also be ignored
        runRequest(0, 3'd3, 34 * DIV0 + 1, 3'd2, lat, rdv, nFr, f0, acc, bad);
        checks++;
        if (rdv !== 32'h4003_03C7) begin errors++; $display("[TB] FAIL done_write_rd: got %h want 400303c7", rdv); end
        repeat (10) @(negedge CLK);
        r = rd0;
        checks++;
        if (r !== 32'h4003_03C7 || frames[0] !== f0 + 1) begin
            errors++; $display("[TB] FAIL done_write_ignored: got rd=%h frames=%0d want rd=400303c7 frames=%0d", r, frames[0] - f0, 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat, nFr, f0;
        logic [31:0] rdv, acc;
        logic bad, reached;
        @(negedge CLK);
        driveWrite(0, 1'b1, 32'd3);
        @(posedge CLK);
        @(negedge CLK);
        driveWrite(0, 1'b0, 32'd0);
        reached = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (slot[0] >= 8) begin reached = 1'b1; break; end
            @(negedge CLK);
        end
        checks++;
        if (reached !== 1'b1) begin errors++; $display("[TB] FAIL midreset_reach_slot7: got %b want 1", reached); end
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({csN0, sclk0} !== 2'b11) begin errors++; $display("[TB] FAIL midreset_cs_sclk: got %b want 11", {csN0, sclk0}); end
        checks++;
        if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rd: got %h want 00000000", rd0); end
        RESET = 1'b0;
        known[0] = 1'b0;
        known[1] = 1'b0;
        runRequest(0, 3'd5, 0, 3'd0, lat, rdv, nFr, f0, acc, bad);
        known[0] = 1'b1; lastCh[0] = 3'd5;
        checks++;
        if (nFr !== 2) begin errors++; $display("[TB] FAIL midreset_after_count: got %0d want 2", nFr); end
        checks++;
        if (lat !== 2 * 34 * DIV0 + 1) begin errors++; $display("[TB] FAIL midreset_after_latency: got %0d want %0d", lat, 2 * 34 * DIV0 + 1); end
        checks++;
        if (rdv !== expWord(3'd5, chanVal[0][5])) begin
            errors++; $display("[TB] FAIL midreset_after_rd: got %h want %h", rdv, expWord(3'd5, chanVal[0][5]));
        end
    endtask

    task automatic test_clkdiv1();
        int lat, nFr, f0;
        logic [31:0] rdv, acc;
        logic bad;
        leadOnes[1] = 1'b1;
        chanVal[1][7] = 12'hFFF;
        runRequest(1, 3'd7, 0, 3'd0, lat, rdv, nFr, f0, acc, bad);
        known[1] = 1'b1; lastCh[1] = 3'd7;
        checks++;
        if (lat !== 2 * 34 * DIV1 + 1) begin errors++; $display("[TB] FAIL div1_latency: got %0d want %0d", lat, 2 * 34 * DIV1 + 1); end
        checks++;
        if (rdv !== 32'h4007_0FFF) begin errors++; $display("[TB] FAIL div1_rd_fff: got %h want 40070fff", rdv); end
        checks++;
        if (sclkPer[1][f0 % 8] !== 2) begin errors++; $display("[TB] FAIL div1_sclk_period: got %0d want 2", sclkPer[1][f0 % 8]); end
        checks++;
        if (frameLen[1][f0 % 8] !== 33) begin errors++; $display("[TB] FAIL div1_cs_low: got %0d want 33", frameLen[1][f0 % 8]); end
        chanVal[1][7] = 12'h000;
        runRequest(1, 3'd7, 0, 3'd0, lat, rdv, nFr, f0, acc, bad);
        checks++;
        if (lat !== 34 * DIV1 + 1) begin errors++; $display("[TB] FAIL div1_repeat_latency: got %0d want %0d", lat, 34 * DIV1 + 1); end
        checks++;
        if (rdv !== 32'h4007_0000) begin errors++; $display("[TB] FAIL div1_rd_000: got %h want 40070000", rdv); end
        leadOnes[1] = 1'b0;
    endtask

    task automatic test_random();
        int u, f, lat, nFr, f0, injAt;
        logic [2:0] ch, injCh;
        logic [11:0] val;
        logic [31:0] rdv, acc;
        logic bad;
        for (int i = 0; i < 12; i++) begin
            u = int'($urandom_range(0, 1));
            ch = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) ch = lastCh[u];
            val = 12'($urandom);
            chanVal[u][ch] = val;
            leadOnes[u] = 1'($urandom);
            f = (known[u] && lastCh[u] == ch) ? 1 : 2;
            injAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, f * 34 * divOf(u) + 1)) : 0;
            injCh = 3'($urandom);
            runRequest(u, ch, injAt, injCh, lat, rdv, nFr, f0, acc, bad);
            known[u] = 1'b1;
            lastCh[u] = ch;
            checks++;
            if (lat !== f * 34 * divOf(u) + 1) begin
                errors++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", i, lat, f * 34 * divOf(u) + 1);
            end
            checks++;
            if (rdv !== expWord(ch, val)) begin
                errors++; $display("[TB] FAIL rand%0d_rd: got %h want %h", i, rdv, expWord(ch, val));
            end
            checks++;
            if (nFr !== f) begin
                errors++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", i, nFr, f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_frame();
        test_same_channel();
        test_busy_write();
        test_reset_mid_frame();
        test_clkdiv1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
